iterative_shifter: RTL and testbench
====================================

Name: iterative_shifter

Overview:
- Parametrised multi-cycle shifter for the ALU datapath; generalises the single-bit right shift.
- Performs one 1-bit step per clock for logical right, logical left, arithmetic right and rotate right.
- Uses a start/busy/done handshake and reports carry-out and zero flags for the ALU status logic.
- Sits beside the combinational ALU; the controller issues start and waits for done.

Parameters:
- WIDTH, 32, data width in bits; must be a power of two and at least 2.
- AMT_W, 32, width of the shift-amount input.
- CNT_W, $clog2(WIDTH)+1, width of the internal step counter (holds 0..WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request; accepted only when busy=0.
- mode  in  2  00 SRL, 01 SLL, 10 SRA, 11 ROR; sampled at acceptance.
- X  in  WIDTH  operand; sampled at acceptance.
- Y  in  AMT_W  shift amount, unsigned; sampled at acceptance.
- Z  out  WIDTH  result register.
- carry  out  1  last bit shifted or rotated out.
- zero  out  1  Z==0, updated with Z.
- busy  out  1  high whenever state!=IDLE.
- done  out  1  one-cycle pulse when Z/carry/zero become valid.

Behaviour:
- Reset (synchronous, rst=1 at an edge): state=IDLE; Z=0, carry=0, zero=0, busy=0, done=0.
  - Reset mid-operation aborts the operation; no done pulse is issued.
  - rst has priority over start.
- States: IDLE, SHIFT, DONE. Moore outputs: busy=(state!=IDLE), done=(state==DONE).
- Acceptance: at an edge with state==IDLE and start=1:
  - load the working register from X; latch mode; clear carry.
  - Step count n = min(Y, WIDTH) for SRL/SLL/SRA; n = Y mod WIDTH (low log2(WIDTH) bits) for ROR.
  - If n==0: next state DONE. Else: next state SHIFT, cnt=n.
- SHIFT: each edge performs one step and decrements cnt; when cnt==1 at the edge, next state is DONE.
  - SRL: shift right, fill 0; carry=bit0 before the step.
  - SLL: shift left, fill 0; carry=bit WIDTH-1 before the step.
  - SRA: shift right, fill the sign bit; carry=bit0 before the step.
  - ROR: bit0 moves to the MSB; carry=bit0 before the step.
- DONE: lasts one cycle, then IDLE.
  - Z, carry and zero hold their values until the next acceptance or reset.
  - zero is computed from the final Z.
- Latency: done is high in the cycle n+1 clocks after the acceptance edge (n=0 gives 1 clock).
- start while busy (SHIFT or DONE): ignored and not queued; inputs may change freely.
- Boundary amounts:
  - Y>=WIDTH with SRL/SLL: Z=0; carry = X[WIDTH-1] (SRL) or X[0] (SLL).
  - Y>=WIDTH with SRA: Z all sign bits; carry=sign.
  - Y=0: Z=X, carry=0.
  - Amounts above 2^CNT_W must clamp, never wrap: compare the full AMT_W bits.
- Working register and Z: the same register, or Z loaded at DONE; either way Z is only guaranteed valid from the done cycle onward.

Decomposition:
- Package shifter_pkg holds:
  - mode encodings: MODE_SRL=2'b00, MODE_SLL=2'b01, MODE_SRA=2'b10, MODE_ROR=2'b11;
  - state encoding: IDLE, SHIFT, DONE (2 bits).
- Sub-module shift_step_1bit (combinational, parameter WIDTH):
  - inputs: data, mode; outputs: next data, out_bit.
  - The FSM instantiates it once per step.
- FSM, counter, clamp/modulo logic and flags live in iterative_shifter.

Test Plan:
- SRL, X=32'hA, Y=1 -> done high 2 cycles after start; Z=32'h5, carry=0, zero=0. Same with Y=2 -> 3 cycles; Z=32'h2, carry=1.
- SRL, X=32'hA, Y=35 -> clamped to 32; done after 33 cycles; Z=0, zero=1, carry=0. Same with Y=32'hFFFFFFFF -> identical result and latency (no counter wrap).
- SRA, X=32'h80000000, Y=4 -> Z=32'hF8000000, carry=0. Same with Y=40 -> Z=32'hFFFFFFFF, carry=1, done after 33 cycles.
- ROR, X=32'hA, Y=35 -> n=3; done after 4 cycles; Z=32'h40000001, carry=0. SLL, X=32'h80000001, Y=1 -> Z=32'h2, carry=1.
- SLL, X=32'h1234, Y=0 -> done 1 cycle after start; Z=32'h1234, carry=0. Pulse start with new X during SHIFT of a Y=8 op -> ignored; first result unaffected; done pulses exactly once.
- Start SRL with Y=20; assert rst at cycle 5 -> next cycle busy=0, Z=0, carry=0, zero=0; no done. New start after rst release completes normally.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative shifter: operation modes and FSM states.
package shifter_pkg;

    localparam logic [1:0] MODE_SRL = 2'b00;
    localparam logic [1:0] MODE_SLL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step_1bit.sv
// One 1-bit shift/rotate step, purely combinational (zero latency, no handshake).
// out_bit_o is the bit that leaves the word on this step.
module shift_step_1bit
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] data_o,
    output logic             out_bit_o
);

    always_comb begin
        data_o    = data_i;
        out_bit_o = 1'b0;
        case (mode_i)
            MODE_SRL: begin
                data_o    = {1'b0, data_i[WIDTH-1:1]};
                out_bit_o = data_i[0];
            end
            MODE_SLL: begin
                data_o    = {data_i[WIDTH-2:0], 1'b0};
                out_bit_o = data_i[WIDTH-1];
            end
            MODE_SRA: begin
                data_o    = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
                out_bit_o = data_i[0];
            end
            default: begin
                data_o    = {data_i[0], data_i[WIDTH-1:1]};
                out_bit_o = data_i[0];
            end
        endcase
    end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter, one bit per clock; done pulses n+1 clocks after the accepting edge.
// start is only taken in IDLE; requests while busy are dropped, not queued.
module iterative_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] X,
    input  logic [AMT_W-1:0] Y,
    output logic [WIDTH-1:0] Z,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int LOG2W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       mode_q, mode_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] step_data;
    logic             step_bit;
    logic [CNT_W-1:0] n_amt;

    shift_step_1bit #(.WIDTH(WIDTH)) u_step (
        .data_i    (data_q),
        .mode_i    (mode_q),
        .data_o    (step_data),
        .out_bit_o (step_bit)
    );

    // Full-width compare so huge amounts clamp to WIDTH instead of wrapping the counter.
    always_comb begin
        if (mode == MODE_ROR) begin
            n_amt = CNT_W'(Y[LOG2W-1:0]);
        end else if (Y >= AMT_W'(WIDTH)) begin
            n_amt = CNT_W'(WIDTH);
        end else begin
            n_amt = Y[CNT_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_d  = X;
                    mode_d  = mode;
                    carry_d = 1'b0;
                    cnt_d   = n_amt;
                    if (n_amt == '0) begin
                        state_d = ST_DONE;
                        zero_d  = (X == '0);
                    end else begin
                        state_d = ST_SHIFT;
                        zero_d  = 1'b0;
                    end
                end
            end
            ST_SHIFT: begin
                data_d  = step_data;
                carry_d = step_bit;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    zero_d  = (step_data == '0);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            mode_q  <= MODE_SRL;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign Z     = data_q;
    assign carry = carry_q;
    assign zero  = zero_q;
    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed checks of the iterative shifter: results, flags, latency, clamping, busy-start and reset abort.
module tb_iterative_shifter;
    import shifter_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] X;
    logic [31:0] Y;
    logic [31:0] Z;
    logic        carry;
    logic        zero;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    iterative_shifter #(.WIDTH(32), .AMT_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .X     (X),
        .Y     (Y),
        .Z     (Z),
        .carry (carry),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one operation and checks latency, result, flags and single done pulse.
    // intr>0 pulses a conflicting start on that edge count while the op is busy.
    task automatic run_op(input string tag, input logic [1:0] m, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_z, input logic exp_c,
                          input int exp_lat, input int intr);
        int cyc;
        int dcount;
        bit seen;
        @(negedge clk);
        mode  = m;
        X     = x;
        Y     = y;
        start = 1'b1;
        cyc    = 0;
        dcount = 0;
        seen   = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (intr > 0 && cyc == intr) begin
                start = 1'b1;
                mode  = MODE_SLL;
                X     = 32'h12345678;
                Y     = 32'd0;
            end
            if (intr > 0 && cyc == intr + 1) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                dcount++;
            end
        end
        start = 1'b0;
        check({tag, ".done_seen"}, 64'(seen), 64'd1);
        check({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, ".Z"}, 64'(Z), 64'(exp_z));
        check({tag, ".carry"}, 64'(carry), 64'(exp_c));
        check({tag, ".zero"}, 64'(zero), 64'(exp_z == 32'd0));
        check({tag, ".busy_at_done"}, 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        check({tag, ".done_pulses"}, 64'(dcount), 64'd1);
        check({tag, ".idle_after"}, 64'(busy), 64'd0);
        check({tag, ".Z_held"}, 64'(Z), 64'(exp_z));
    endtask

    initial begin
        int dseen;
        rst   = 1'b1;
        start = 1'b0;
        mode  = MODE_SRL;
        X     = 32'd0;
        Y     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.Z", 64'(Z), 64'd0);
        check("reset.carry", 64'(carry), 64'd0);
        check("reset.zero", 64'(zero), 64'd0);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("srl_y1",     MODE_SRL, 32'hA,        32'd1,          32'h5,        1'b0, 2,  0);
        run_op("srl_y2",     MODE_SRL, 32'hA,        32'd2,          32'h2,        1'b1, 3,  0);
        run_op("srl_y35",    MODE_SRL, 32'hA,        32'd35,         32'h0,        1'b0, 33, 0);
        run_op("srl_ymax",   MODE_SRL, 32'hA,        32'hFFFFFFFF,   32'h0,        1'b0, 33, 0);
        run_op("sra_y4",     MODE_SRA, 32'h80000000, 32'd4,          32'hF8000000, 1'b0, 5,  0);
        run_op("sra_y40",    MODE_SRA, 32'h80000000, 32'd40,         32'hFFFFFFFF, 1'b1, 33, 0);
        run_op("ror_y32",    MODE_ROR, 32'hA,        32'd32,         32'hA,        1'b0, 1,  0);
        run_op("sra_pos40",  MODE_SRA, 32'h7FFFFFFF, 32'd40,         32'h0,        1'b0, 33, 0);
        run_op("ror_y35",    MODE_ROR, 32'hA,        32'd35,         32'h40000001, 1'b0, 4,  0);
        run_op("sll_y1",     MODE_SLL, 32'h80000001, 32'd1,          32'h2,        1'b1, 2,  0);
        run_op("sll_y32",    MODE_SLL, 32'h1,        32'd32,         32'h0,        1'b1, 33, 0);
        run_op("sll_y0",     MODE_SLL, 32'h1234,     32'd0,          32'h1234,     1'b0, 1,  0);
        run_op("srl_busy",   MODE_SRL, 32'hFF80,     32'd8,          32'hFF,       1'b1, 9,  3);

        // Abort a long operation with reset partway through.
        @(negedge clk);
        mode  = MODE_SRL;
        X     = 32'hFFFFFFFF;
        Y     = 32'd20;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort.busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.Z", 64'(Z), 64'd0);
        check("abort.carry", 64'(carry), 64'd0);
        check("abort.zero", 64'(zero), 64'd0);
        check("abort.done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dseen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done) dseen++;
        end
        check("abort.no_done", 64'(dseen), 64'd0);

        run_op("post_reset", MODE_SRL, 32'hA,        32'd1,          32'h5,        1'b0, 2,  0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
